// File: rtl/accum_share_sched.sv
// accum_share_sched: round-robin shared accumulate/bypass/load datapath with per-requester contexts and one registered response
module accum_share_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       req_bypass,
   input  logic [NREQ-1:0]       req_load,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data
);
   logic [WIDTH-1:0] ctx_q [NREQ];
   logic [WIDTH-1:0] ctx_d [NREQ];
   logic [IDW-1:0]   rr_q, rr_d, win;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             found, accept;
   logic [IDW:0]     cand;
   logic [WIDTH-1:0] opnd, res;

   // first valid requester found searching upward from rr, wrapping past NREQ-1
   always_comb begin
      found = 1'b0;
      win = '0;
      cand = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_q} + (IDW+1)'(k);
         cand = (cand >= (IDW+1)'(NREQ)) ? cand - (IDW+1)'(NREQ) : cand;
         if (!found && req_valid[cand[IDW-1:0]]) begin
            found = 1'b1;
            win = cand[IDW-1:0];
         end
      end
   end

   assign accept    = found && (!rsp_valid_q || rsp_ready) && !rst;
   assign req_ready = accept ? (NREQ'(1) << win) : '0;
   assign opnd      = req_data[win*WIDTH +: WIDTH];
   assign res       = (req_load[win] || req_bypass[win]) ? opnd : ctx_q[win] + opnd;

   // next state: update the granted context, advance the pointer, refill or drain the response slot
   always_comb begin
      ctx_d = ctx_q;
      rr_d = rr_q;
      rsp_valid_d = rsp_valid_q && !rsp_ready;
      rsp_id_d = rsp_id_q;
      rsp_data_d = rsp_data_q;
      if (accept) begin
         if (req_load[win] || !req_bypass[win]) ctx_d[win] = res;
         rr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
         rsp_valid_d = 1'b1;
         rsp_id_d = win;
         rsp_data_d = res;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ctx_q <= '{default: '0};
         rr_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q <= '0;
         rsp_data_q <= '0;
      end else begin
         ctx_q <= ctx_d;
         rr_q <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_accum_share_sched.sv
// tb_accum_share_sched: directed stimulus checked every cycle against a behavioural scheduler model
module tb_accum_share_sched;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid = '0, req_ready, req_bypass = '0, req_load = '0;
   logic [127:0] req_data = '0;
   logic         rsp_valid, rsp_ready = 1'b1;
   logic [1:0]   rsp_id;
   logic [31:0]  rsp_data;

   logic         rst2 = 1'b1;
   logic [1:0]   r2_valid = '0, r2_ready;
   logic [63:0]  r2_data = '0;
   logic         r2_rsp_valid;
   logic [0:0]   r2_rsp_id;
   logic [31:0]  r2_rsp_data;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   accum_share_sched #(.NREQ(4), .WIDTH(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .req_bypass(req_bypass), .req_load(req_load), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data));

   accum_share_sched #(.NREQ(2), .WIDTH(32)) dut2 (
      .clk(clk), .rst(rst2), .req_valid(r2_valid), .req_ready(r2_ready), .req_data(r2_data),
      .req_bypass(2'b00), .req_load(2'b00), .rsp_valid(r2_rsp_valid), .rsp_ready(1'b1),
      .rsp_id(r2_rsp_id), .rsp_data(r2_rsp_data));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model: contexts, pointer and response register as plain variables
   logic [31:0] m_ctx [4] = '{default: 0};
   int          m_rr = 0;
   int          m_gw = -1;
   bit          m_v = 1'b0;
   int          m_id = 0;
   logic [31:0] m_data = '0;
   logic [31:0] m_d;

   function automatic int pick();
      if (m_v && !rsp_ready) return -1;
      for (int k = 0; k < 4; k++) if (req_valid[(m_rr + k) % 4]) return (m_rr + k) % 4;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ctx = '{default: 0};
         m_rr = 0; m_v = 0; m_id = 0; m_data = 0; m_gw = -1;
      end else begin
         m_gw = pick();
         if (m_gw >= 0) begin
            m_d = req_data[m_gw*32 +: 32];
            if (req_load[m_gw]) m_ctx[m_gw] = m_d;
            else if (!req_bypass[m_gw]) begin
               m_ctx[m_gw] = m_ctx[m_gw] + m_d;
               m_d = m_ctx[m_gw];
            end
            m_v = 1; m_id = m_gw; m_data = m_d; m_rr = (m_gw + 1) % 4;
         end else if (!m_v || rsp_ready) m_v = 0;
      end
   end

   int w;
   always @(negedge clk) begin
      if (chk_on) begin
         w = rst ? -1 : pick();
         check("req_ready", {60'd0, req_ready}, (w < 0) ? 64'd0 : (64'd1 << w));
         check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_v});
         check("rsp_id", {62'd0, rsp_id}, 64'(m_id));
         check("rsp_data", {32'd0, rsp_data}, {32'd0, m_data});
      end
   end

   typedef struct {int id; logic [31:0] d;} rec_t;
   rec_t got[$];
   rec_t exp_q[$];

   always @(posedge clk) if (!rst && rsp_valid && rsp_ready) got.push_back('{int'(rsp_id), rsp_data});

   typedef struct {logic [31:0] d; bit byp; bit ld;} op_t;
   op_t q[4][$];

   task automatic push(input int i, input logic [31:0] d, input bit byp = 0, input bit ld = 0);
      q[i].push_back('{d, byp, ld});
   endtask

   task automatic expect_rsp(input int id, input logic [31:0] d);
      exp_q.push_back('{id, d});
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = q[i].size() != 0;
         req_data[i*32 +: 32] = q[i].size() != 0 ? q[i][0].d : 32'd0;
         req_bypass[i] = q[i].size() != 0 ? q[i][0].byp : 1'b0;
         req_load[i] = q[i].size() != 0 ? q[i][0].ld : 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (m_gw >= 0 && q[m_gw].size() != 0) void'(q[m_gw].pop_front());
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic cmp_got(input string nm);
      check({nm, "_count"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check({nm, "_id"}, 64'(got[i].id), 64'(exp_q[i].id));
         check({nm, "_data"}, {32'd0, got[i].d}, {32'd0, exp_q[i].d});
      end
      got.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) q[i].delete();
      drive();
      run(2);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk_on = 1'b1;
      got.delete();

      for (int k = 0; k < 4; k++) push(0, 32'd5);
      drive();
      run(6);
      expect_rsp(0, 5); expect_rsp(0, 10); expect_rsp(0, 15); expect_rsp(0, 20);
      cmp_got("chain");
      check("model_ctx0", {32'd0, m_ctx[0]}, 64'd20);

      do_reset();
      got.delete();
      for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) push(i, 32'(100*i + 1));
      drive();
      run(10);
      expect_rsp(0, 1); expect_rsp(1, 101); expect_rsp(2, 201); expect_rsp(3, 301);
      expect_rsp(0, 2); expect_rsp(1, 202); expect_rsp(2, 402); expect_rsp(3, 602);
      cmp_got("rotate");

      push(2, 32'd40, 0, 1);
      push(2, 32'd7, 1, 0);
      push(2, 32'd1);
      push(2, 32'hFFFF_FFFF, 0, 1);
      push(2, 32'd2);
      drive();
      run(7);
      expect_rsp(2, 40); expect_rsp(2, 7); expect_rsp(2, 41); expect_rsp(2, 32'hFFFF_FFFF); expect_rsp(2, 1);
      cmp_got("bypass_load");
      check("model_ctx2", {32'd0, m_ctx[2]}, 64'd1);

      push(0, 32'd10);
      push(1, 32'd20);
      drive();
      step();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         #3;
         check("stall_ready", {60'd0, req_ready}, 64'd0);
         check("stall_data", {32'd0, rsp_data}, 64'd12);
      end
      rsp_ready = 1'b1;
      run(4);
      expect_rsp(0, 12); expect_rsp(1, 222);
      cmp_got("stall");

      do_reset();
      got.delete();
      push(1, 32'd50, 0, 1);
      drive();
      step();
      check("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
      rst = 1'b1;
      push(0, 32'd9);
      push(1, 32'd3);
      drive();
      step();
      rst = 1'b0;
      check("post_rst_valid", {63'd0, rsp_valid}, 64'd0);
      run(4);
      expect_rsp(0, 9); expect_rsp(1, 3);
      cmp_got("mid_reset");

      @(posedge clk);
      #1;
      rst2 = 1'b0;
      r2_valid = 2'b10;
      r2_data = {32'd5, 32'd0};
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("n2_ready", {62'd0, r2_ready}, 64'd2);
         @(posedge clk);
         #1;
         check("n2_valid", {63'd0, r2_rsp_valid}, 64'd1);
         check("n2_id", {63'd0, r2_rsp_id}, 64'd1);
         check("n2_data", {32'd0, r2_rsp_data}, 64'(5*k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/accum_share_sched.md
# accum_share_sched

Round-robin scheduler that shares one accumulate/bypass datapath between `NREQ` requesters. Each requester owns a private accumulator context. The block grants at most one request per cycle, applies accumulate, bypass or load to that requester's context, and returns the result through a single registered response port with backpressure. It sits between the per-lane generators and the protected accumulator core, so lanes no longer need their own datapath copies.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `WIDTH`, default 32: data and context width in bits.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  NREQ  bit i set: requester i has a request.
- `req_ready`  out  NREQ  bit i set: request i is accepted this cycle; at most one bit is set (one-hot).
- `req_data`  in  NREQ*WIDTH  operand; requester i uses bits [i*WIDTH +: WIDTH].
- `req_bypass`  in  NREQ  bit i: requester i's request is a bypass (no context update).
- `req_load`  in  NREQ  bit i: requester i's request loads its context with the operand.
- `rsp_valid`  out  1  response holding register is full.
- `rsp_ready`  in  1  downstream accepts the response.
- `rsp_id`  out  IDW  requester index of the response.
- `rsp_data`  out  WIDTH  result value.

## Operation
- State held:
  - `ctx[0..NREQ-1]`, each WIDTH bits.
  - round-robin pointer `rr`, IDW bits.
  - response register: valid, id, data.
- Slot free when `!rsp_valid || rsp_ready`.
- Arbitration, when slot free: winner is the first i with `req_valid[i]` set, searching `rr, rr+1, …, NREQ-1, 0, …` (wraps mod NREQ).
  - `req_ready[winner]` = 1; all other bits 0.
  - Slot not free, or no valid request: `req_ready` = 0.
- On accept of requester i with operand d (checked in priority order):
  - `req_load` set: ctx[i] ← d; result = d.
  - else `req_bypass` set: ctx[i] unchanged; result = d.
  - else: ctx[i] ← ctx[i] + d, truncated mod 2^WIDTH, no carry out; result = ctx[i] + d (the new value).
  - Response register ← {1, i, result}.
  - rr ← (i+1) mod NREQ.
- Slot free with no accept: `rsp_valid` ← 0; id and data hold.
- Only the accepted requester's context changes; all other contexts are untouched.
- Requester rules (violations are undefined):
  - `req_valid` stays high until accepted.
  - `req_data`, `req_bypass` and `req_load` stay stable while valid and not yet ready.

## Timing
- Reset (`rst` high at posedge):
  - all ctx = 0; rr = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - While `rst` is high, `req_ready` is forced to 0.
- Reset mid-operation:
  - A pending response is dropped; no handshake completes in the reset cycle.
  - Contexts clear even if a request is valid.
- `req_ready` is combinational from `req_valid`, `rr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_data` to any output.
- Latency: accept at edge N gives `rsp_valid` = 1 with the result after edge N.
- Throughput: one response per cycle while `rsp_ready` is held at 1.
- Full-rate drain: `rsp_valid` and `rsp_ready` both high with a new accept loads the register on the same edge with no bubble.
- Stall: with `rsp_ready` = 0 and `rsp_valid` = 1, no requester is accepted and rsp outputs hold stable.
- Back-to-back requests from the same requester chain correctly: the second uses the context value updated by the first.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…. Each requester waits at most NREQ-1 accepted cycles.

## Test plan
- Reset, then requester 0 sends 5 four times with `rsp_ready` = 1:
  - responses 5, 10, 15, 20, all with id 0, on consecutive cycles.
  - ctx[0] = 20.
- All four requesters continuously valid with data = 100*i + 1, `rsp_ready` = 1:
  - id sequence 0,1,2,3,0,1,2,3.
  - data sequence 1,101,201,301,2,202,402,602.
- Requester 2 sends bypass with 7 after context 40:
  - response 7; next plain request with 1 returns 41.
  - Load with 0xFFFF_FFFF, then add 2: response 1 (wrap).
- Hold `rsp_ready` = 0 for 3 cycles with requests pending:
  - `req_ready` = 0 throughout; rsp outputs stable.
  - On release, no response is lost or duplicated.
- Assert `rst` for one cycle with `rsp_valid` = 1 and ctx[1] = 50:
  - next cycle `rsp_valid` = 0.
  - requester 1 adding 3 returns 3; grant restarts at requester 0.
- NREQ = 2, only requester 1 valid: accepted every cycle and rr stays at 0.
